// File: rtl/alu_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit_if
// Description : Operand, opcode and result bundle for alu_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_unit_if;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic [3:0]  i_alu_op;
    logic [31:0] o_alu_data;
    logic        o_zero;
    logic [31:0] o_alu_data_q;
    logic        o_illegal_op;

    modport slave (
        input  i_op_a,
        input  i_op_b,
        input  i_alu_op,
        output o_alu_data,
        output o_zero,
        output o_alu_data_q,
        output o_illegal_op
    );

    modport master (
        output i_op_a,
        output i_op_b,
        output i_alu_op,
        input  o_alu_data,
        input  o_zero,
        input  o_alu_data_q,
        input  o_illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit
// Description : 32-bit integer ALU, combinational result plus a one-cycle
//               registered copy. Macro ALU_ILLEGAL_OP_EN enables the sticky
//               illegal-opcode flag; otherwise o_illegal_op is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_unit (
    input  logic       i_clk,
    input  logic       i_reset,
    alu_unit_if.slave  bus
);

    localparam logic [3:0] c_OP_ADD    = 4'b0000;
    localparam logic [3:0] c_OP_SUB    = 4'b0001;
    localparam logic [3:0] c_OP_SLL    = 4'b0010;
    localparam logic [3:0] c_OP_SLT    = 4'b0011;
    localparam logic [3:0] c_OP_SLTU   = 4'b0100;
    localparam logic [3:0] c_OP_XOR    = 4'b0101;
    localparam logic [3:0] c_OP_SRL    = 4'b0110;
    localparam logic [3:0] c_OP_SRA    = 4'b0111;
    localparam logic [3:0] c_OP_OR     = 4'b1000;
    localparam logic [3:0] c_OP_AND    = 4'b1001;
    localparam logic [3:0] c_OP_PASS_B = 4'b1010;

    logic [31:0] w_alu_data_d;
    logic [31:0] r_alu_data_q;
    logic [4:0]  w_shamt;

    assign w_shamt = bus.i_op_b[4:0];

    always_comb begin
        w_alu_data_d = 32'h0;
        case (bus.i_alu_op)
            c_OP_ADD:    w_alu_data_d = bus.i_op_a + bus.i_op_b;
            c_OP_SUB:    w_alu_data_d = bus.i_op_a - bus.i_op_b;
            c_OP_SLL:    w_alu_data_d = bus.i_op_a << w_shamt;
            c_OP_SLT:    w_alu_data_d = {31'b0, $signed(bus.i_op_a) < $signed(bus.i_op_b)};
            c_OP_SLTU:   w_alu_data_d = {31'b0, bus.i_op_a < bus.i_op_b};
            c_OP_XOR:    w_alu_data_d = bus.i_op_a ^ bus.i_op_b;
            c_OP_SRL:    w_alu_data_d = bus.i_op_a >> w_shamt;
            c_OP_SRA:    w_alu_data_d = $unsigned($signed(bus.i_op_a) >>> w_shamt);
            c_OP_OR:     w_alu_data_d = bus.i_op_a | bus.i_op_b;
            c_OP_AND:    w_alu_data_d = bus.i_op_a & bus.i_op_b;
            c_OP_PASS_B: w_alu_data_d = bus.i_op_b;
            default:     w_alu_data_d = 32'h0;
        endcase
    end

    assign bus.o_alu_data   = w_alu_data_d;
    assign bus.o_zero       = (w_alu_data_d == 32'h0);
    assign bus.o_alu_data_q = r_alu_data_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_alu_data_q <= 32'h0;
        end else begin
            r_alu_data_q <= w_alu_data_d;
        end
    end

`ifdef ALU_ILLEGAL_OP_EN
    logic w_illegal_d;
    logic r_illegal_q;

    // Unassigned opcodes are 1011-1111, i.e. everything above PASS_B.
    assign w_illegal_d = r_illegal_q | (bus.i_alu_op > c_OP_PASS_B);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_illegal_q <= 1'b0;
        end else begin
            r_illegal_q <= w_illegal_d;
        end
    end

    assign bus.o_illegal_op = r_illegal_q;
`else
    assign bus.o_illegal_op = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_unit
// Description : Self-checking bench for alu_unit: directed corner vectors
//               followed by randomized operations against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_unit;

`ifdef ALU_ILLEGAL_OP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [31:0] exp_q;
    logic        exp_ill;

    alu_unit_if bus ();

    alu_unit u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint sa;
        longint sb;
        sh = b[4:0];
        sa = (a[31]) ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb = (b[31]) ? longint'(b) - 64'sd4294967296 : longint'(b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present one operation, check the combinational outputs, then the
    // registered outputs after the following rising edge.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic r);
        logic [31:0] exp;
        @(negedge clk);
        bus.i_alu_op = op;
        bus.i_op_a   = a;
        bus.i_op_b   = b;
        rst          = r;
        exp = ref_alu(op, a, b);
        #1;
        check("alu_data", bus.o_alu_data, exp);
        check("zero", {31'b0, bus.o_zero}, {31'b0, exp == 32'd0});
        if (r) begin
            exp_q   = 32'd0;
            exp_ill = 1'b0;
        end else begin
            exp_q = exp;
            if (ILL_EN && op > 4'd10) exp_ill = 1'b1;
        end
        @(posedge clk);
        #1;
        check("alu_data_q", bus.o_alu_data_q, exp_q);
        check("illegal_op", {31'b0, bus.o_illegal_op}, {31'b0, exp_ill});
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        r;
        n_checks     = 0;
        n_errors     = 0;
        exp_q        = 32'd0;
        exp_ill      = 1'b0;
        rst          = 1'b1;
        bus.i_alu_op = 4'd0;
        bus.i_op_a   = 32'd0;
        bus.i_op_b   = 32'd0;

        step(4'd0, 32'd0, 32'd0, 1'b1);
        step(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);

        step(4'd0,  32'hFFFF_FFFF, 32'h1,         1'b0);
        step(4'd1,  32'h0,         32'h1,         1'b0);
        step(4'd3,  32'h8000_0000, 32'h1,         1'b0);
        step(4'd4,  32'h8000_0000, 32'h1,         1'b0);
        step(4'd3,  32'h1234_5678, 32'h1234_5678, 1'b0);
        step(4'd2,  32'h8000_0010, 32'h24,        1'b0);
        step(4'd6,  32'h8000_0010, 32'h24,        1'b0);
        step(4'd7,  32'h8000_0010, 32'h24,        1'b0);
        step(4'd7,  32'h8000_0010, 32'hFFFF_FFE0, 1'b0);
        step(4'd10, 32'hDEAD_BEEF, 32'h1234_5000, 1'b0);
        step(4'd15, 32'hDEAD_BEEF, 32'h1234_5000, 1'b0);

        step(4'd0, 32'd5, 32'd7, 1'b1);
        step(4'd0, 32'd5, 32'd7, 1'b0);

        step(4'd12, 32'h1, 32'h2, 1'b0);
        step(4'd5,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        step(4'd9,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        step(4'd8,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        step(4'd0,  32'd1, 32'd1, 1'b1);
        step(4'd0,  32'd1, 32'd1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 7) == 0) a = {a[31], 31'd0};
            r  = ($urandom_range(0, 24) == 0);
            step(op, a, b, r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 The module SHALL use synchronous, active-high reset on a single clock; all registered state SHALL be updated on the rising edge of i_clk only.
REQ-002 i_clk  input  1  system clock.
REQ-003 i_reset  input  1  synchronous active-high reset.
REQ-004 i_op_a  input  32  operand A (rs1, PC or zero, selected upstream).
REQ-005 i_op_b  input  32  operand B (rs2 or immediate, selected upstream).
REQ-006 i_alu_op  input  4  operation select.
REQ-007 o_alu_data  output  32  combinational result.
REQ-008 o_zero  output  1  combinational; 1 when o_alu_data == 0.
REQ-009 o_alu_data_q  output  32  result registered one cycle.
REQ-010 o_illegal_op  output  1  sticky illegal-opcode flag (see Configuration).

Function
REQ-011 o_alu_data SHALL be purely combinational from i_op_a, i_op_b, i_alu_op, with zero-cycle latency and no dependence on i_clk or i_reset.
REQ-012 Opcodes: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B.
REQ-013 ADD/SUB SHALL be modulo 2^32 and wrap silently, with no carry or overflow output.
REQ-014 SLT SHALL compare two's-complement signed values; SLTU SHALL compare unsigned; both SHALL return 32'h1 if A<B, else 32'h0.
REQ-015 Shift amount SHALL be i_op_b[4:0]; i_op_b[31:5] SHALL be ignored; SRA SHALL replicate A[31]; shift by 0 SHALL return A.
REQ-016 PASS_B SHALL return i_op_b unchanged (used for LUI).
REQ-017 Opcodes 1011-1111 SHALL produce o_alu_data = 32'h0.
REQ-018 o_alu_data_q SHALL load o_alu_data every rising edge when i_reset=0.

Reset
REQ-019 When i_reset=1 at a rising edge, o_alu_data_q SHALL become 32'h0 and o_illegal_op SHALL become 0.
REQ-020 Reset SHALL NOT affect o_alu_data or o_zero, which stay combinational during reset.
REQ-021 Reset asserted mid-stream SHALL take priority over any simultaneous capture or flag set in that cycle.

Configuration
REQ-022 Macro ALU_ILLEGAL_OP_EN defined: o_illegal_op SHALL be set at a rising edge (i_reset=0) when i_alu_op is in 1011-1111, and SHALL remain 1 until reset.
REQ-023 Macro ALU_ILLEGAL_OP_EN undefined: o_illegal_op SHALL be tied to constant 0 and no flag register SHALL exist; all other behaviour is identical.

Verification
REQ-024 ADD A=32'hFFFF_FFFF, B=32'h1 -> o_alu_data=0, o_zero=1; SUB A=0, B=1 -> 32'hFFFF_FFFF, o_zero=0.
REQ-025 A=32'h8000_0000, B=32'h1: SLT -> 1, SLTU -> 0; SLT with A=B -> 0.
REQ-026 A=32'h8000_0010, B=32'h24 (amount 4): SLL -> 32'h0000_0100, SRL -> 32'h0800_0001, SRA -> 32'hF800_0001.
REQ-027 PASS_B B=32'h1234_5000 -> 32'h1234_5000; opcode 4'b1111 -> 0; o_alu_data_q shows each result one cycle later.
REQ-028 Assert i_reset for one cycle while driving ADD 5+7 -> o_alu_data=12 immediately, o_alu_data_q=0 after the edge, and 12 on the next edge after reset is released.
REQ-029 With ALU_ILLEGAL_OP_EN defined: opcode 4'b1100 for one cycle -> o_illegal_op=1 and held through later legal ops until reset; without the macro it SHALL stay 0.
